// File: rtl/core_pkg.sv
// Shared definitions for the five-stage core: opcodes, ALU and immediate-format
// encodings, the decoded control bundle and the main decoder.
package core_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned REG_AW   = 5;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_t;

  typedef struct packed {
    logic       reg_wrt;
    logic       alu_src;
    logic       mem_wrt;
    logic       result_src;
    logic       branch;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  // ALU operation from funct3; subtract only for R-type with funct7[5] set.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic sub);
    case (funct3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Main control decoder; unknown opcodes decode to all-zero controls.
  function automatic ctrl_t decode_ctrl(input logic [6:0] op, input logic [2:0] funct3,
                                        input logic funct7_b5);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LW: begin
        c.reg_wrt    = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = 1'b1;
        c.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        c.mem_wrt  = 1'b1;
        c.alu_src  = 1'b1;
        c.alu_ctrl = ALU_ADD;
      end
      OP_R: begin
        c.reg_wrt  = 1'b1;
        c.alu_ctrl = alu_decode(funct3, funct7_b5);
      end
      OP_I: begin
        c.reg_wrt  = 1'b1;
        c.alu_src  = 1'b1;
        c.alu_ctrl = alu_decode(funct3, 1'b0);
      end
      OP_BEQ: begin
        c.branch   = 1'b1;
        c.alu_ctrl = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Immediate format per opcode; I-format is the fallback for everything else.
  function automatic imm_src_t imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// D-stage, write-back and E-stage signal bundle of the decode stage.
// master: drives D-stage instruction, hold/flush and write-back; sees E outputs.
// slave : the decode stage itself.
interface decode_stage_pipe_if #(
  parameter int unsigned XLEN = core_pkg::XLEN_DEF
);
  logic            valid_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc4_d;
  logic            hold_e;
  logic            flush_e;
  logic            reg_write_w;
  logic [4:0]      rd_w;
  logic [XLEN-1:0] result_w;

  logic            stall_fd;
  logic            valid_e;
  logic            reg_wrt_e;
  logic            alu_src_e;
  logic            mem_wrt_e;
  logic            result_src_e;
  logic            branch_e;
  logic [2:0]      alu_ctrl_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;
  logic [XLEN-1:0] pc_e;
  logic [XLEN-1:0] pc4_e;
  logic [4:0]      rs1_e;
  logic [4:0]      rs2_e;
  logic [4:0]      rd_e;

  modport master (
    output valid_d, instr_d, pc_d, pc4_d, hold_e, flush_e, reg_write_w, rd_w, result_w,
    input  stall_fd, valid_e, reg_wrt_e, alu_src_e, mem_wrt_e, result_src_e, branch_e,
           alu_ctrl_e, rd1_e, rd2_e, imm_e, pc_e, pc4_e, rs1_e, rs2_e, rd_e
  );

  modport slave (
    input  valid_d, instr_d, pc_d, pc4_d, hold_e, flush_e, reg_write_w, rd_w, result_w,
    output stall_fd, valid_e, reg_wrt_e, alu_src_e, mem_wrt_e, result_src_e, branch_e,
           alu_ctrl_e, rd1_e, rd2_e, imm_e, pc_e, pc4_e, rs1_e, rs2_e, rd_e
  );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with write-through reads.
// Ports: clk, rst_n (async clear of all entries), we/wa/wd write port,
// ra1/ra2 read addresses, rd1_c/rd2_c combinational read data.
// x0 and addresses >= NREG read 0; writes to them are dropped.
module regfile_bypass #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1_c,
  output logic [XLEN-1:0] rd2_c
);
  localparam int unsigned AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [5:0]  NREG_W = 6'(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_en;
  logic            ra1_ok;
  logic            ra2_ok;

  // Address is implemented and not x0.
  assign wr_en  = we && ({1'b0, wa} < NREG_W) && (wa != 5'd0);
  assign ra1_ok = ({1'b0, ra1} < NREG_W) && (ra1 != 5'd0);
  assign ra2_ok = ({1'b0, ra2} < NREG_W) && (ra2 != 5'd0);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[AW'(wa)] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_q <= '{default: '0};
    else        mem_q <= mem_d;
  end

  // Same-cycle write to the read address is forwarded.
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (ra1_ok) rd1_c = (wr_en && (ra1 == wa)) ? wd : mem_q[AW'(ra1)];
    if (ra2_ok) rd2_c = (wr_en && (ra2 == wa)) ? wd : mem_q[AW'(ra2)];
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with ID/EX pipeline register: decodes instr_d, reads the
// register file (write-back forwarded), detects load-use hazards and loads
// either the decoded instruction or a bubble into E.
// Ports: clk, rst_n (async active-low), bus (slave side of decode_stage_pipe_if);
// bus.stall_fd is the only combinational output.
module decode_stage_pipe
  import core_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = 32
) (
  input logic               clk,
  input logic               rst_n,
  decode_stage_pipe_if.slave bus
);
  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } idex_t;

  logic [INSTR_W-1:0] instr;
  logic [6:0]         op_d;
  logic [REG_AW-1:0]  rs1_d;
  logic [REG_AW-1:0]  rs2_d;
  logic [XLEN-1:0]    rd1_c;
  logic [XLEN-1:0]    rd2_c;
  logic [XLEN-1:0]    imm_c;
  idex_t              issue_c;
  idex_t              idex_d;
  idex_t              idex_q;
  logic               haz;

  assign instr = bus.instr_d;
  assign op_d  = instr[6:0];
  assign rs1_d = instr[19:15];
  assign rs2_d = instr[24:20];

  regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bus.reg_write_w),
    .wa    (bus.rd_w),
    .wd    (bus.result_w),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .rd1_c (rd1_c),
    .rd2_c (rd2_c)
  );

  // Sign-extended immediate.
  always_comb begin
    imm_c = '0;
    unique case (imm_src_of(op_d))
      IMM_S:   imm_c = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm_c = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      default: imm_c = {{(XLEN-12){instr[31]}}, instr[31:20]};
    endcase
  end

  // Decoded D-stage instruction; controls of an invalid slot are zeroed.
  always_comb begin
    issue_c       = '0;
    issue_c.valid = bus.valid_d;
    issue_c.ctrl  = bus.valid_d ? decode_ctrl(op_d, instr[14:12], instr[30]) : '0;
    issue_c.rd1   = rd1_c;
    issue_c.rd2   = rd2_c;
    issue_c.imm   = imm_c;
    issue_c.pc    = bus.pc_d;
    issue_c.pc4   = bus.pc4_d;
    issue_c.rs1   = rs1_d;
    issue_c.rs2   = rs2_d;
    issue_c.rd    = instr[11:7];
  end

  // Load in E whose destination is a source of the valid D instruction.
  assign haz = idex_q.valid && idex_q.ctrl.result_src && (idex_q.rd != '0) &&
               bus.valid_d && ((idex_q.rd == rs1_d) || (idex_q.rd == rs2_d));

  // A held E stage already freezes the upstream, so no stall request then.
  assign bus.stall_fd = haz && !bus.hold_e;

  // ID/EX update: flush > hold > load-use bubble > issue.
  always_comb begin
    idex_d = idex_q;
    if (bus.flush_e)     idex_d = '0;
    else if (bus.hold_e) idex_d = idex_q;
    else if (haz)        idex_d = '0;
    else                 idex_d = issue_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.valid_e      = idex_q.valid;
  assign bus.reg_wrt_e    = idex_q.ctrl.reg_wrt;
  assign bus.alu_src_e    = idex_q.ctrl.alu_src;
  assign bus.mem_wrt_e    = idex_q.ctrl.mem_wrt;
  assign bus.result_src_e = idex_q.ctrl.result_src;
  assign bus.branch_e     = idex_q.ctrl.branch;
  assign bus.alu_ctrl_e   = idex_q.ctrl.alu_ctrl;
  assign bus.rd1_e        = idex_q.rd1;
  assign bus.rd2_e        = idex_q.rd2;
  assign bus.imm_e        = idex_q.imm;
  assign bus.pc_e         = idex_q.pc;
  assign bus.pc4_e        = idex_q.pc4;
  assign bus.rs1_e        = idex_q.rs1;
  assign bus.rs2_e        = idex_q.rs2;
  assign bus.rd_e         = idex_q.rd;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Testbench for decode_stage_pipe: a 32-bit/32-register instance checked
// against a behavioural model, plus a 64-bit/16-register instance.
module tb_decode_stage_pipe;
  logic clk;
  logic rst_n;

  decode_stage_pipe_if #(.XLEN(32)) if32 ();
  decode_stage_pipe_if #(.XLEN(64)) if64 ();

  decode_stage_pipe #(.XLEN(32), .NREG(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
  decode_stage_pipe #(.XLEN(64), .NREG(16)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic        reg_wrt;
    logic        alu_src;
    logic        mem_wrt;
    logic        result_src;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } e32_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [7:0]  ctrl;   // reg_wrt, alu_src, mem_wrt, result_src, branch, alu_ctrl[2:0]
    logic [31:0] imm;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  e32_t        m;            // model of the E-stage register contents
  logic [31:0] rf [32];      // model of the architectural registers
  vec_t        vecs [10];
  e32_t        snap;

  task automatic chkv(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic e32_t dut32_e();
    e32_t r;
    r.valid = if32.valid_e;     r.reg_wrt = if32.reg_wrt_e;   r.alu_src = if32.alu_src_e;
    r.mem_wrt = if32.mem_wrt_e; r.result_src = if32.result_src_e;
    r.branch = if32.branch_e;   r.alu_ctrl = if32.alu_ctrl_e;
    r.rd1 = if32.rd1_e; r.rd2 = if32.rd2_e; r.imm = if32.imm_e;
    r.pc = if32.pc_e;   r.pc4 = if32.pc4_e;
    r.rs1 = if32.rs1_e; r.rs2 = if32.rs2_e; r.rd = if32.rd_e;
    return r;
  endfunction

  function automatic logic [2:0] model_alu(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Register read as seen this cycle, including the write-back in flight.
  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (if32.reg_write_w && if32.rd_w == a) return if32.result_w;
    return rf[a];
  endfunction

  // What the E stage should hold after issuing the current D instruction.
  function automatic e32_t model_issue();
    e32_t        r;
    logic [31:0] i;
    i = if32.instr_d;
    r = '0;
    r.valid = if32.valid_d;
    r.pc = if32.pc_d; r.pc4 = if32.pc4_d;
    r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7];
    r.rd1 = model_read(i[19:15]);
    r.rd2 = model_read(i[24:20]);
    case (i[6:0])
      7'h23:   r.imm = 32'($signed({i[31:25], i[11:7]}));
      7'h63:   r.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      default: r.imm = 32'($signed(i[31:20]));
    endcase
    if (if32.valid_d) begin
      case (i[6:0])
        7'h03: begin r.reg_wrt = 1'b1; r.alu_src = 1'b1; r.result_src = 1'b1; end
        7'h23: begin r.mem_wrt = 1'b1; r.alu_src = 1'b1; end
        7'h33: begin r.reg_wrt = 1'b1; r.alu_ctrl = model_alu(i[14:12], i[30]); end
        7'h13: begin r.reg_wrt = 1'b1; r.alu_src = 1'b1; r.alu_ctrl = model_alu(i[14:12], 1'b0); end
        7'h63: begin r.branch = 1'b1; r.alu_ctrl = 3'b001; end
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic model_haz();
    logic [31:0] i;
    i = if32.instr_d;
    return m.valid && m.result_src && (m.rd != 5'd0) && if32.valid_d &&
           ((m.rd == i[19:15]) || (m.rd == i[24:20]));
  endfunction

  task automatic model_reset();
    m = '0;
    for (int k = 0; k < 32; k++) rf[k] = 32'd0;
  endtask

  // One clock of the 32-bit instance; starts and ends at a falling edge.
  task automatic cycle();
    e32_t nxt;
    logic haz;
    #1;
    haz = model_haz();
    chkv("stall_fd", 256'(if32.stall_fd), 256'(haz && !if32.hold_e));
    if (if32.flush_e)     nxt = '0;
    else if (if32.hold_e) nxt = m;
    else if (haz)         nxt = '0;
    else                  nxt = model_issue();
    @(posedge clk);
    if (if32.reg_write_w && if32.rd_w != 5'd0) rf[if32.rd_w] = if32.result_w;
    m = nxt;
    #1;
    chkv("e_regs", 256'(dut32_e()), 256'(m));
    @(negedge clk);
  endtask

  task automatic idle32();
    if32.valid_d = 1'b0; if32.instr_d = '0; if32.pc_d = '0; if32.pc4_d = '0;
    if32.hold_e = 1'b0;  if32.flush_e = 1'b0;
    if32.reg_write_w = 1'b0; if32.rd_w = '0; if32.result_w = '0;
  endtask

  task automatic idle64();
    if64.valid_d = 1'b0; if64.instr_d = '0; if64.pc_d = '0; if64.pc4_d = '0;
    if64.hold_e = 1'b0;  if64.flush_e = 1'b0;
    if64.reg_write_w = 1'b0; if64.rd_w = '0; if64.result_w = '0;
  endtask

  task automatic issue32(input logic [31:0] ins);
    if32.valid_d = 1'b1; if32.instr_d = ins; if32.hold_e = 1'b0; if32.flush_e = 1'b0;
    if32.reg_write_w = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chkv({tag, "_e32"}, 256'({dut32_e(), if32.stall_fd}), 256'(0));
    chkv({tag, "_e64"}, 256'({if64.valid_e, if64.reg_wrt_e, if64.branch_e, if64.result_src_e,
                              if64.rd1_e, if64.imm_e, if64.pc4_e, if64.rd_e, if64.stall_fd}),
         256'(0));
  endtask

  initial begin
    vecs[0] = '{32'h0080A203, 8'b11010_000, 32'd8};          // lw x4,8(x1)
    vecs[1] = '{32'hFE512E23, 8'b01100_000, 32'hFFFF_FFFC};  // sw x5,-4(x2)
    vecs[2] = '{32'h000281B3, 8'b10000_000, 32'd0};          // add x3,x5,x0
    vecs[3] = '{32'h402081B3, 8'b10000_001, 32'h0000_0402}; // sub x3,x1,x2
    vecs[4] = '{32'h0020F1B3, 8'b10000_010, 32'd2};          // and
    vecs[5] = '{32'h0020E1B3, 8'b10000_011, 32'd2};          // or
    vecs[6] = '{32'h0020A1B3, 8'b10000_101, 32'd2};          // slt
    vecs[7] = '{32'hFE208EE3, 8'b00001_001, 32'hFFFF_FFFC};  // beq x1,x2,-4
    vecs[8] = '{32'hFFF08313, 8'b11000_000, 32'hFFFF_FFFF};  // addi x6,x1,-1
    vecs[9] = '{32'h0000007F, 8'b00000_000, 32'd0};          // unknown opcode

    rst_n = 1'b1;
    idle32(); idle64();
    model_reset();
    #2 rst_n = 1'b0;

    // Reset held with random inputs: everything stays zero across clock edges.
    @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      if32.valid_d = 1'b1; if32.instr_d = $urandom; if32.pc_d = $urandom;
      if32.pc4_d = $urandom; if32.hold_e = 1'($urandom); if32.flush_e = 1'($urandom);
      if32.reg_write_w = 1'b1; if32.rd_w = 5'($urandom); if32.result_w = $urandom;
      if64.valid_d = 1'b1; if64.instr_d = 32'hFE208EE3; if64.pc_d = {$urandom, $urandom};
      if64.reg_write_w = 1'b1; if64.rd_w = 5'd3; if64.result_w = {$urandom, $urandom};
      #1 check_all_zero("rst_hold");
      @(posedge clk); #1 check_all_zero("rst_edge");
      @(negedge clk);
    end
    idle32(); idle64();
    rst_n = 1'b1;

    // First read after reset: x5 is 0.
    issue32(32'h000281B3);
    cycle();
    chkv("rst_read_x5", 256'(if32.rd1_e), 256'(0));

    // Write-back forwarded into the same-cycle read.
    issue32(32'h000281B3);
    if32.reg_write_w = 1'b1; if32.rd_w = 5'd5; if32.result_w = 32'h1234;
    cycle();
    chkv("bypass", 256'({if32.rd1_e, if32.rd_e, if32.reg_wrt_e}), 256'({32'h1234, 5'd3, 1'b1}));

    // Decode table, an idle slot between entries so no hazard interferes.
    for (int v = 0; v < 10; v++) begin
      issue32(vecs[v].instr);
      if32.pc_d = 32'h100 + 32'(v * 4); if32.pc4_d = if32.pc_d + 32'd4;
      cycle();
      chkv("dec_ctrl", 256'({if32.reg_wrt_e, if32.alu_src_e, if32.mem_wrt_e, if32.result_src_e,
                             if32.branch_e, if32.alu_ctrl_e}), 256'(vecs[v].ctrl));
      chkv("dec_imm", 256'(if32.imm_e), 256'(vecs[v].imm));
      if32.valid_d = 1'b0;
      cycle();
      chkv("invalid_ctrl", 256'({if32.valid_e, if32.reg_wrt_e, if32.alu_src_e, if32.mem_wrt_e,
                                 if32.result_src_e, if32.branch_e, if32.alu_ctrl_e}), 256'(0));
    end

    // Load-use: one stall cycle, one bubble, then the dependent add issues.
    issue32(32'h0080A203);
    cycle();
    issue32(32'h00220333);
    #1 chkv("lu_stall", 256'(if32.stall_fd), 256'(1));
    cycle();
    chkv("lu_bubble", 256'(dut32_e()), 256'(0));
    #1 chkv("lu_no_stall", 256'(if32.stall_fd), 256'(0));
    cycle();
    chkv("lu_issue", 256'({if32.valid_e, if32.rs1_e, if32.rd_e}), 256'({1'b1, 5'd4, 5'd6}));

    // Flush beats hold beats hazard; stall_fd is low while held.
    issue32(32'h0080A203);
    cycle();
    issue32(32'h00220333);
    if32.hold_e = 1'b1; if32.flush_e = 1'b1;
    #1 chkv("flush_stall", 256'(if32.stall_fd), 256'(0));
    cycle();
    chkv("flush_bubble", 256'(dut32_e()), 256'(0));

    // Hold for three cycles with changing D-stage inputs.
    issue32(32'h000281B3);
    if32.pc_d = 32'h2000; if32.pc4_d = 32'h2004;
    cycle();
    snap = m;
    for (int h = 0; h < 3; h++) begin
      if32.hold_e = 1'b1; if32.instr_d = $urandom; if32.pc_d = $urandom;
      if32.reg_write_w = 1'b1; if32.rd_w = 5'd5; if32.result_w = $urandom;
      cycle();
      chkv("hold", 256'(dut32_e()), 256'(snap));
    end

    // Asynchronous reset between edges, with a load-use stall pending.
    idle32();
    issue32(32'h0080A203);
    cycle();
    issue32(32'h00220333);
    #1 chkv("pre_rst_stall", 256'(if32.stall_fd), 256'(1));
    #1 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    idle32();
    rst_n = 1'b1;
    issue32(32'h000281B3);
    cycle();
    chkv("rf_cleared", 256'(if32.rd1_e), 256'(0));

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: ins[6:0] = 7'h03;
        1: ins[6:0] = 7'h23;
        2: ins[6:0] = 7'h33;
        3: ins[6:0] = 7'h63;
        4: ins[6:0] = 7'h13;
        default: ;
      endcase
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      ins[11:7]  = 5'($urandom_range(0, 7));
      if32.instr_d = ins;
      if32.valid_d = ($urandom_range(0, 9) < 8);
      if32.hold_e  = ($urandom_range(0, 99) < 15);
      if32.flush_e = ($urandom_range(0, 99) < 10);
      if32.pc_d = $urandom; if32.pc4_d = if32.pc_d + 32'd4;
      if32.reg_write_w = 1'($urandom);
      if32.rd_w = 5'($urandom_range(0, 7));
      if32.result_w = $urandom;
      cycle();
    end
    idle32();

    // 64-bit / 16-register instance.
    if64.valid_d = 1'b1; if64.instr_d = 32'hFE208EE3;
    if64.pc_d = 64'h1_0000_0000; if64.pc4_d = 64'h1_0000_0004;
    @(posedge clk); #1;
    chkv("x64_beq_imm", 256'(if64.imm_e), 256'(64'hFFFF_FFFF_FFFF_FFFC));
    chkv("x64_beq_ctl", 256'({if64.branch_e, if64.alu_ctrl_e, if64.valid_e, if64.pc4_e}),
         256'({1'b1, 3'b001, 1'b1, 64'h1_0000_0004}));
    @(negedge clk);
    idle64();
    if64.reg_write_w = 1'b1; if64.rd_w = 5'd20; if64.result_w = 64'hDEAD_BEEF_0000_0020;
    @(negedge clk);
    if64.rd_w = 5'd15; if64.result_w = 64'h8000_0000_0000_0001;
    @(negedge clk);
    if64.reg_write_w = 1'b0;
    if64.valid_d = 1'b1; if64.instr_d = 32'h00FA01B3;  // add x3,x20,x15
    @(posedge clk); #1;
    chkv("x64_rd_x20", 256'(if64.rd1_e), 256'(0));
    chkv("x64_rd_x15", 256'(if64.rd2_e), 256'(64'h8000_0000_0000_0001));
    @(negedge clk);
    idle64();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_stage_pipe.md
# decode_stage_pipe

Parametrised decode stage with an ID/EX pipeline register, for the five-stage core. It decodes the D-stage instruction and reads an internal register file with write-back bypass. It detects load-use hazards and launches either a decoded instruction or a bubble into the E stage. Unlike the first-generation stage, it adds:

- configurable data width and register count
- a valid bit
- external hold and flush control
- automatic load-use bubble insertion

## Interface

Parameters:

- XLEN, 32, datapath width of register data, PC and immediates (≥32)
- NREG, 32, implemented architectural registers (2..32); addresses ≥ NREG read 0, writes ignored

Ports:

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low (already decided)
- valid_d  in  1  D-stage instruction valid
- instr_d  in  32  D-stage instruction (RV32 encoding)
- pc_d, pc4_d  in  XLEN  PC and PC+4 of instr_d
- hold_e  in  1  keep ID/EX register contents unchanged
- flush_e  in  1  load a bubble into ID/EX (taken branch)
- reg_write_w  in  1  write-back enable
- rd_w  in  5  write-back destination
- result_w  in  XLEN  write-back data
- stall_fd  out  1  combinational load-use stall request to IF and IF/ID
- valid_e, reg_wrt_e, alu_src_e, mem_wrt_e, result_src_e, branch_e  out  1 each  registered control
- alu_ctrl_e  out  3  registered ALU control
- rd1_e, rd2_e, imm_e, pc_e, pc4_e  out  XLEN  registered data
- rs1_e, rs2_e, rd_e  out  5  registered instr_d[19:15], [24:20], [11:7]

## Operation

**Decode**
- Op = instr_d[6:0]; funct3 = [14:12]; funct7 = [31:25].
- Control values:
  - lw: RegWrt 1, ALUSrc 1, ResultSrc 1.
  - sw: MemWrt 1, ALUSrc 1.
  - R-type: RegWrt 1.
  - beq: Branch 1, ALU subtract (alu_ctrl 001).
  - add: alu_ctrl 000.
- Immediate, sign-extended to XLEN:
  - I-type: [31:20]
  - S-type: {[31:25],[11:7]}
  - B-type: {[31],[7],[30:25],[11:8],1'b0}

**Register file**
- NREG×XLEN storage; x0 reads 0 and is never written.
- Write on rising clk when reg_write_w=1 and rd_w≠0.
- Read ports are combinational and write-through: a read address equal to rd_w (≠0) with reg_write_w=1 returns result_w in the same cycle.

**Load-use hazard**
- haz = valid_e & result_src_e & (rd_e≠0) & valid_d & (rd_e==rs1_d | rd_e==rs2_d).
- stall_fd = haz & ~hold_e.
- rs2 is compared for all opcodes; false stalls are accepted.

**ID/EX register update, priority order**
1. flush_e → bubble
2. hold_e → hold all fields
3. haz → bubble
4. otherwise → load the decoded instruction; valid_e=valid_d
- In a bubble every output register, including valid_e and data/address fields, is 0.
- A control field of an invalid instruction (valid_d=0) is forced to 0.

## Timing

- Latency: instr_d sampled at edge N appears on the *_e outputs after edge N.
- Only stall_fd is combinational; its path is E-register → comparator → output.
- A flush_e and hold_e in the same cycle: flush wins.
- A haz and hold_e in the same cycle: hold wins, and stall_fd=0 (the upstream holds via its own hold).
- Write and read of the same register in the same cycle: rd1_e/rd2_e capture result_w.
- Reset assertion, at any time including mid-hold or mid-bubble: immediately clears all outputs, valid_e and every register-file entry to 0. stall_fd falls to 0 with them.
- Reset deassertion: first capture on the next rising clk.
- Register address wrap is not possible; addresses ≥ NREG are treated as x0 for reads.

## Structure

- Shared package core_pkg holds:
  - opcode constants (OP_LW, OP_SW, OP_R, OP_BEQ, OP_I)
  - ALU control encodings
  - ImmSrc encodings
  - XLEN default
- Sub-module regfile_bypass (params XLEN, NREG): storage, reset clear and write-through reads.
- Decode, immediate extension, hazard logic and the ID/EX register live in the top.

## Test plan

1. **Reset:** hold rst=0 with random inputs → all outputs 0, including valid_e=0 and stall_fd=0. Release, then read x5 → rd1_e=0.
2. **Bypass:** reg_write_w=1, rd_w=5, result_w=0x1234 while instr_d=add x3,x5,x0 (0x000281B3) → next cycle rd1_e=0x1234, rd_e=3, reg_wrt_e=1.
3. **Load-use:**
   - lw x4,8(x1) (0x0080A203), then add x6,x4,x2 (0x00220333) held at D.
   - Required: stall_fd=1 for one cycle, then a bubble with valid_e=0 and all controls 0.
   - The following cycle: add issues with rs1_e=4.
4. **Flush priority:** flush_e=1, hold_e=1 and haz=1 together → bubble loaded, stall_fd=0.
5. **Hold:** hold_e=1 for 3 cycles with a changing instr_d → *_e stay equal to the pre-hold values.
6. **Parametrised build:** XLEN=64, NREG=16.
   - beq with negative offset (0xFE208EE3) → imm_e=0xFFFF_FFFF_FFFF_FFFC, branch_e=1.
   - Write to x20 is ignored; a read of x20 gives 0.
